// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: prefetches from a synchronous instruction ROM into a small queue feeding decode.
// A fetch issues only when a slot is reserved for it, so pushes never find the queue full.
module inst_fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        O_inst_addr,
  output logic                     O_fetch_en,
  input  logic [INST_W-1:0]        I_inst,
  input  logic                     I_redirect,
  input  logic [ADDR_W-1:0]        I_redirect_addr,
  output logic                     O_valid,
  output logic [INST_W-1:0]        O_inst,
  output logic [ADDR_W-1:0]        O_pc,
  input  logic                     I_ready,
  output logic [$clog2(DEPTH):0]   O_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] pc, inflight_addr;
  logic              inflight, push, pop;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  assign O_fetch_en = !rst && !I_redirect && (count + CW'(inflight) < CW'(DEPTH));
  assign O_inst_addr = pc;
  // A redirect squashes the word returning this cycle and overrides any pop
  assign push = inflight && !I_redirect;
  assign pop = O_valid && I_ready && !I_redirect;
  assign O_valid = count != '0;
  assign O_count = count;
  assign O_inst = mem_inst[rd_ptr];
  assign O_pc = mem_pc[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_addr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (I_redirect) begin
      pc <= I_redirect_addr;
      inflight <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (O_fetch_en) pc <= pc + ADDR_W'(1);
      inflight <= O_fetch_en;
      inflight_addr <= pc;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_inst[wr_ptr] <= I_inst;
      mem_pc[wr_ptr] <= inflight_addr;
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed stimulus with a queue-level reference model checked every cycle.
module tb_inst_fetch_queue;
  localparam int AW = 8, IW = 16, D = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic          redir, ready;
  logic [AW-1:0] raddr, addr, pc, addr2, pc2;
  logic [IW-1:0] rom_q, inst, rom_q2, inst2;
  logic          fe, valid, fe2, valid2;
  logic [2:0]    count, count2;
  inst_fetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .O_inst_addr(addr), .O_fetch_en(fe), .I_inst(rom_q),
    .I_redirect(redir), .I_redirect_addr(raddr), .O_valid(valid), .O_inst(inst),
    .O_pc(pc), .I_ready(ready), .O_count(count));
  inst_fetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .RESET_PC(8'hFE)) dut2 (
    .clk(clk), .rst(rst), .O_inst_addr(addr2), .O_fetch_en(fe2), .I_inst(rom_q2),
    .I_redirect(1'b0), .I_redirect_addr(8'h00), .O_valid(valid2), .O_inst(inst2),
    .O_pc(pc2), .I_ready(1'b1), .O_count(count2));
  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    return IW'(a) + 16'h0100;
  endfunction
  always @(posedge clk) begin
    rom_q <= rom(addr);
    rom_q2 <= rom(addr2);
  end
  typedef struct packed {logic [AW-1:0] pc; logic [IW-1:0] inst;} ent_t;
  ent_t q[$];
  logic [AW-1:0] mpc = 8'h00, mia = 8'h00;
  bit minf = 1'b0;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_step();
    bit mfe;
    if (rst) begin
      chk("rst_valid", valid, 0);
      chk("rst_fetch_en", fe, 0);
      chk("rst_count", count, 0);
      q.delete();
      mpc = 8'h00;
      minf = 1'b0;
      return;
    end
    mfe = !redir && (q.size() + minf < D);
    chk("fetch_en", fe, mfe);
    if (mfe) chk("inst_addr", addr, mpc);
    chk("count", count, q.size());
    chk("valid", valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("head_pc", pc, q[0].pc);
      chk("head_inst", inst, q[0].inst);
    end
    if (redir) begin
      q.delete();
      minf = 1'b0;
      mpc = raddr;
    end else begin
      if (ready && q.size() != 0) void'(q.pop_front());
      if (minf) q.push_back(ent_t'{mia, rom(mia)});
      minf = mfe;
      mia = mpc;
      if (mfe) mpc++;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int nfe;
    ready = 1'b1; redir = 1'b0; raddr = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("c0_fetch_en", fe, 1);
    chk("c0_addr", addr, 8'h00);
    tick(); tick();
    chk("c2_valid", valid, 1);
    chk("c2_pc", pc, 8'h00);
    chk("c2_inst", inst, 16'h0100);
    chk("wrap_pc_fe", pc2, 8'hFE);
    tick();
    chk("c3_pc", pc, 8'h01);
    chk("c3_inst", inst, 16'h0101);
    chk("wrap_pc_ff", pc2, 8'hFF);
    tick();
    chk("wrap_pc_00", pc2, 8'h00);
    tick();
    chk("wrap_pc_01", pc2, 8'h01);
    repeat (4) tick();
    chk("steady_count", count, 1);
    redir = 1'b1; raddr = 8'h30;
    tick();
    redir = 1'b0;
    chk("redir_pop_count", count, 0);
    tick();
    chk("redir_gap_valid", valid, 0);
    tick();
    chk("redir_target_pc", pc, 8'h30);
    redir = 1'b1; raddr = 8'h80;
    tick();
    raddr = 8'h90;
    tick();
    redir = 1'b0;
    tick(); tick();
    chk("b2b_valid", valid, 1);
    chk("b2b_pc", pc, 8'h90);
    redir = 1'b1; raddr = 8'hFD;
    tick();
    redir = 1'b0;
    repeat (8) tick();
    ready = 1'b0; redir = 1'b1; raddr = 8'h10;
    tick();
    redir = 1'b0;
    repeat (4) tick();
    chk("squash_count", count, 3);
    chk("squash_pc", pc, 8'h10);
    redir = 1'b1; raddr = 8'h40;
    tick();
    redir = 1'b0; ready = 1'b1;
    chk("squash_gap1", valid, 0);
    tick();
    chk("squash_gap2", valid, 0);
    tick();
    chk("squash_pc40", pc, 8'h40);
    chk("squash_inst40", inst, 16'h0140);
    repeat (3) tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; ready = 1'b0;
    #1;
    nfe = 0;
    for (int c = 0; c < 10; c++) begin
      if (fe) nfe++;
      tick();
    end
    chk("stall_fetches", nfe, 4);
    chk("stall_count", count, 4);
    chk("stall_fetch_en", fe, 0);
    chk("stall_pc", pc, 8'h00);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", valid, 1);
      chk("drain_pc", pc, i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0;
    repeat (4) tick();
    chk("pre_rst_count", count, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", valid, 0);
    chk("async_count", count, 0);
    tick();
    rst = 1'b0; ready = 1'b1;
    tick(); tick();
    chk("restart_valid", valid, 1);
    chk("restart_pc", pc, 8'h00);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
